// File: rtl/mem_responder_if.sv
// CPU memory bus and host program-load handshake between the CPU/host side and mem_responder.
interface mem_responder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
);
    logic [1:0]            mem_cmd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;

    modport master (
        output mem_cmd, mem_addr, write_data, load_valid, load_data, load_last,
        input  read_data, load_ready
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data, load_valid, load_data, load_last,
        output read_data, load_ready
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: RAM, LED/switch I/O registers and a boot loader that
// holds the CPU in reset until the host has streamed the program into RAM.
module mem_responder #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    RAM_WORDS  = 256,
    parameter logic [ADDR_WIDTH-1:0] LED_ADDR   = 9'h100,
    parameter logic [ADDR_WIDTH-1:0] SW_ADDR    = 9'h140
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus,
    input  logic [7:0]     sw,
    output logic [7:0]     led,
    output logic           cpu_hold,
    output logic           bad_access,
    output logic           load_overflow
);
    localparam int         PTR_W     = $clog2(RAM_WORDS);
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

    typedef enum logic {LOAD, RUN} state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] ram [RAM_WORDS];
    logic [PTR_W-1:0]      load_ptr;
    logic [PTR_W-1:0]      cpu_idx;
    logic                  accept, last_slot;
    logic                  ram_hit, led_hit, sw_hit;
    logic                  ram_we;
    logic [PTR_W-1:0]      ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] rd_next;

    assign cpu_idx   = bus.mem_addr[PTR_W-1:0];
    assign accept    = bus.load_valid && bus.load_ready;
    assign last_slot = (load_ptr == PTR_W'(RAM_WORDS - 1));
    assign ram_hit   = (bus.mem_addr < ADDR_WIDTH'(RAM_WORDS));
    assign led_hit   = (bus.mem_addr == LED_ADDR);
    assign sw_hit    = (bus.mem_addr == SW_ADDR);

    always_ff @(posedge clk) begin
        if (!reset) state <= LOAD;
        else        state <= state_next;
    end

    // Loading ends on the tagged last word, or when the final RAM slot is filled.
    always_comb begin
        state_next = state;
        if (state == LOAD && accept && (bus.load_last || last_slot))
            state_next = RUN;
    end

    always_comb begin
        cpu_hold       = 1'b0;
        bus.load_ready = 1'b0;
        if (state == LOAD) begin
            cpu_hold       = 1'b1;
            bus.load_ready = 1'b1;
        end
    end

    // The single RAM write port is owned by the loader in LOAD and by the CPU in RUN.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = load_ptr;
        ram_wdata = bus.load_data;
        if (state == LOAD) begin
            ram_we = accept;
        end else if (bus.mem_cmd == CMD_WRITE && ram_hit) begin
            ram_we    = 1'b1;
            ram_waddr = cpu_idx;
            ram_wdata = bus.write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && ram_we)
            ram[ram_waddr] <= ram_wdata;
    end

    always_comb begin
        rd_next = '0;
        if (ram_hit)     rd_next = ram[cpu_idx];
        else if (sw_hit) rd_next = {{(DATA_WIDTH-8){1'b0}}, sw};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.read_data <= '0;
            led           <= '0;
            load_ptr      <= '0;
            bad_access    <= 1'b0;
            load_overflow <= 1'b0;
        end else if (state == LOAD) begin
            if (accept) begin
                load_ptr <= last_slot ? '0 : load_ptr + 1'b1;
                if (last_slot && !bus.load_last)
                    load_overflow <= 1'b1;
            end
        end else begin
            case (bus.mem_cmd)
                CMD_READ: begin
                    bus.read_data <= rd_next;
                    if (!ram_hit && !sw_hit)
                        bad_access <= 1'b1;
                end
                CMD_WRITE: begin
                    if (led_hit)       led        <= bus.write_data[7:0];
                    else if (!ram_hit) bad_access <= 1'b1;
                end
                CMD_RSVD: bad_access <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a behavioural model checked every cycle
// plus directed vectors with hand-computed expectations.
module tb_mem_responder;
    localparam logic [1:0] NONE  = 2'b00;
    localparam logic [1:0] READ  = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;
    localparam logic [1:0] RSVD  = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw;
    logic [7:0] led;
    logic       cpu_hold;
    logic       bad_access;
    logic       load_overflow;

    int checkCount = 0;
    int passCount  = 0;

    mem_responder_if bus ();

    mem_responder dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus.slave),
        .sw            (sw),
        .led           (led),
        .cpu_hold      (cpu_hold),
        .bad_access    (bad_access),
        .load_overflow (load_overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: the responder is either loading or running, nothing more.
    logic [15:0] m_ram [256];
    int          m_ptr;
    bit          m_hold, m_bad, m_ovf, m_valid = 1'b0;
    logic [15:0] m_rd;
    logic [7:0]  m_led;

    always @(posedge clk) begin
        if (!reset) begin
            m_rd = '0; m_led = '0; m_ptr = 0;
            m_bad = 1'b0; m_ovf = 1'b0; m_hold = 1'b1; m_valid = 1'b1;
        end else if (m_valid && m_hold) begin
            if (bus.load_valid) begin
                m_ram[m_ptr] = bus.load_data;
                if (bus.load_last) m_hold = 1'b0;
                else if (m_ptr == 255) begin
                    m_hold = 1'b0;
                    m_ovf  = 1'b1;
                end
                m_ptr = (m_ptr + 1) % 256;
            end
        end else if (m_valid) begin
            if (bus.mem_cmd == READ) begin
                if (bus.mem_addr < 256)         m_rd = m_ram[bus.mem_addr];
                else if (bus.mem_addr == 9'h140) m_rd = {8'h00, sw};
                else begin
                    m_rd  = '0;
                    m_bad = 1'b1;
                end
            end else if (bus.mem_cmd == WRITE) begin
                if (bus.mem_addr < 256)          m_ram[bus.mem_addr] = bus.write_data;
                else if (bus.mem_addr == 9'h100) m_led = bus.write_data[7:0];
                else                             m_bad = 1'b1;
            end else if (bus.mem_cmd == RSVD) begin
                m_bad = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model_read_data", bus.read_data, m_rd);
            checkOutput("model_led", led, m_led);
            checkOutput("model_cpu_hold", cpu_hold, m_hold);
            checkOutput("model_load_ready", bus.load_ready, m_hold);
            checkOutput("model_bad_access", bad_access, m_bad);
            checkOutput("model_load_overflow", load_overflow, m_ovf);
        end
    end

    // Drives one cycle of inputs just after a negedge and returns at the next negedge.
    task automatic applyStimulus(input logic rst, input logic [1:0] cmd, input logic [8:0] addr,
                                 input logic [15:0] wd, input logic lv, input logic [15:0] ld,
                                 input logic ll);
        reset          = rst;
        bus.mem_cmd    = cmd;
        bus.mem_addr   = addr;
        bus.write_data = wd;
        bus.load_valid = lv;
        bus.load_data  = ld;
        bus.load_last  = ll;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; sw = 8'h00;
        bus.mem_cmd = NONE; bus.mem_addr = '0; bus.write_data = '0;
        bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
        @(negedge clk);
        applyStimulus(0, NONE, 0, 0, 1, 16'hBAD0, 0);
        applyStimulus(0, NONE, 0, 0, 0, 0, 0);
        checkOutput("reset_cpu_hold", cpu_hold, 16'd1);
        checkOutput("reset_load_ready", bus.load_ready, 16'd1);
        checkOutput("reset_read_data", bus.read_data, 16'h0000);
        checkOutput("reset_led", led, 16'h0000);

        // Three-word load with a gap after the second word.
        applyStimulus(1, READ, 9'h140, 0, 1, 16'hA5A5, 0);
        applyStimulus(1, NONE, 0, 0, 1, 16'h1234, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, NONE, 0, 0, 0, 16'hDEAD, 0);
        checkOutput("gap_cpu_hold", cpu_hold, 16'd1);
        applyStimulus(1, NONE, 0, 0, 1, 16'hFFFF, 1);
        checkOutput("load_done_cpu_hold", cpu_hold, 16'd0);
        checkOutput("load_done_ready", bus.load_ready, 16'd0);

        applyStimulus(1, READ, 9'd0, 0, 0, 0, 0);
        checkOutput("read_addr0", bus.read_data, 16'hA5A5);
        applyStimulus(1, READ, 9'd2, 0, 0, 0, 0);
        checkOutput("read_addr2", bus.read_data, 16'hFFFF);
        applyStimulus(1, READ, 9'd1, 0, 0, 0, 0);
        checkOutput("read_addr1", bus.read_data, 16'h1234);
        applyStimulus(1, WRITE, 9'h100, 16'h00C3, 0, 0, 0);
        checkOutput("led_write", led, 16'h00C3);
        checkOutput("read_hold_after_write", bus.read_data, 16'h1234);
        checkOutput("bad_clear", bad_access, 16'd0);

        sw = 8'h5A;
        applyStimulus(1, READ, 9'h140, 0, 0, 0, 0);
        checkOutput("read_switches", bus.read_data, 16'h005A);
        applyStimulus(1, READ, 9'h180, 0, 0, 0, 0);
        checkOutput("read_unmapped_data", bus.read_data, 16'h0000);
        checkOutput("read_unmapped_bad", bad_access, 16'd1);

        applyStimulus(1, WRITE, 9'd5, 16'h7777, 0, 0, 0);
        applyStimulus(1, READ, 9'd5, 0, 0, 0, 0);
        checkOutput("write_then_read", bus.read_data, 16'h7777);
        applyStimulus(1, WRITE, 9'd3, 16'h4444, 0, 0, 0);
        applyStimulus(1, NONE, 0, 0, 1, 16'hBEEF, 1);
        applyStimulus(1, READ, 9'd3, 0, 0, 0, 0);
        checkOutput("load_ignored_in_run", bus.read_data, 16'h4444);
        applyStimulus(1, WRITE, 9'h100, 16'hA53C, 0, 0, 0);
        checkOutput("led_low_byte", led, 16'h003C);

        // Full RAM load without a last marker.
        applyStimulus(0, NONE, 0, 0, 0, 0, 0);
        checkOutput("reset2_led", led, 16'h0000);
        checkOutput("reset2_bad", bad_access, 16'd0);
        checkOutput("reset2_read_data", bus.read_data, 16'h0000);
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1, NONE, 0, 0, 1, 16'(i * 3 + 16'h0100), 0);
            if (i == 254) checkOutput("ovf_not_yet_hold", cpu_hold, 16'd1);
        end
        checkOutput("ovf_flag", load_overflow, 16'd1);
        checkOutput("ovf_run", cpu_hold, 16'd0);
        applyStimulus(1, READ, 9'd255, 0, 0, 0, 0);
        checkOutput("ovf_read_255", bus.read_data, 16'h03FD);
        applyStimulus(1, RSVD, 9'd0, 16'h9999, 0, 0, 0);
        checkOutput("reserved_bad", bad_access, 16'd1);
        applyStimulus(1, READ, 9'd0, 0, 0, 0, 0);
        checkOutput("reserved_no_write", bus.read_data, 16'h0100);
        applyStimulus(1, WRITE, 9'h100, 16'h00AA, 0, 0, 0);

        // Reset part-way through a load restarts at address 0.
        applyStimulus(0, NONE, 0, 0, 0, 0, 0);
        applyStimulus(1, NONE, 0, 0, 1, 16'h1111, 0);
        applyStimulus(1, NONE, 0, 0, 1, 16'h2222, 0);
        applyStimulus(0, NONE, 0, 0, 0, 0, 0);
        checkOutput("midload_reset_hold", cpu_hold, 16'd1);
        checkOutput("midload_reset_led", led, 16'h0000);
        checkOutput("midload_reset_ovf", load_overflow, 16'd0);
        applyStimulus(1, NONE, 0, 0, 1, 16'h3333, 1);
        applyStimulus(1, READ, 9'd0, 0, 0, 0, 0);
        checkOutput("restart_addr0", bus.read_data, 16'h3333);
        applyStimulus(1, READ, 9'd1, 0, 0, 0, 0);
        checkOutput("ram_kept_addr1", bus.read_data, 16'h2222);
        applyStimulus(1, READ, 9'd2, 0, 0, 0, 0);
        checkOutput("ram_kept_addr2", bus.read_data, 16'h0106);
        applyStimulus(1, WRITE, 9'h0FF + 9'd2, 16'h1234, 0, 0, 0);
        checkOutput("write_unmapped_bad", bad_access, 16'd1);
        applyStimulus(1, NONE, 0, 0, 0, 0, 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
